// File: rtl/instr_encoder_if.sv
// Instruction-field stream into the encoder plus the instruction-memory write port.
// The master side is the program source and memory model; the slave side is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              is_rtype;
  logic [5:0]        code;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  // A field transfer happens on the rising edge where in_valid && in_ready; a memory
  // write completes on the edge where imem_we && imem_ack, with addr/wdata held until then.
  modport master (
    output in_valid, is_rtype, code, rs, rt, rd, shamt, imm, target, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, is_rtype, code, rs, rt, rd, shamt, imm, target, imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instruction fields into 32-bit words and writes them to
// instruction memory at an auto-incrementing address until SYSCALL or memory full.
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              restart,
    instr_encoder_if.slave    bus,
    output logic              err_illegal,
    output logic              halted,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_HALTED = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    state_t            state;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              sys_q;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              enc_sys;

    // Field packing; fields a format does not use are forced to zero.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        enc_sys   = 1'b0;
        if (bus.is_rtype) begin
            case (bus.code)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h18, 6'h1A, 6'h04, 6'h06: begin
                    enc_legal = 1'b1;
                    enc_word  = {6'd0, bus.rs, bus.rt, bus.rd, 5'd0, bus.code};
                end
                6'h00, 6'h02, 6'h03: begin
                    enc_legal = 1'b1;
                    enc_word  = {6'd0, 5'd0, bus.rt, bus.rd, bus.shamt, bus.code};
                end
                6'h08: begin
                    enc_legal = 1'b1;
                    enc_word  = {6'd0, bus.rs, 15'd0, 6'h08};
                end
                6'h0C: begin
                    enc_legal = 1'b1;
                    enc_sys   = 1'b1;
                    enc_word  = 32'h0000_000C;
                end
                default: ;
            endcase
        end else begin
            case (bus.code)
                6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                6'h23, 6'h2B, 6'h04, 6'h05: begin
                    enc_legal = 1'b1;
                    enc_word  = {bus.code, bus.rs, bus.rt, bus.imm};
                end
                6'h06, 6'h07: begin
                    enc_legal = 1'b1;
                    enc_word  = {bus.code, bus.rs, 5'd0, bus.imm};
                end
                6'h01: begin
                    // BGEZ is REGIMM with rt selecting the condition.
                    enc_legal = 1'b1;
                    enc_word  = {6'h01, bus.rs, 5'd1, bus.imm};
                end
                6'h02, 6'h03: begin
                    enc_legal = 1'b1;
                    enc_word  = {bus.code, bus.target};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            sys_q       <= 1'b0;
            err_illegal <= 1'b0;
            halted      <= 1'b0;
            full        <= 1'b0;
            word_count  <= '0;
        end else begin
            err_illegal <= 1'b0;
            if (restart) begin
                // Abandons any write still waiting for its ack.
                state      <= S_IDLE;
                in_ready_q <= 1'b1;
                we_q       <= 1'b0;
                addr_q     <= BASE_ADDR;
                halted     <= 1'b0;
                full       <= 1'b0;
                word_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            if (enc_legal) begin
                                wdata_q    <= enc_word;
                                sys_q      <= enc_sys;
                                state      <= S_WRITE;
                                in_ready_q <= 1'b0;
                                we_q       <= 1'b1;
                            end else begin
                                err_illegal <= 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (bus.imem_ack) begin
                            we_q       <= 1'b0;
                            word_count <= word_count + 1'b1;
                            if (sys_q) begin
                                state  <= S_HALTED;
                                halted <= 1'b1;
                                full   <= (addr_q == '1);
                            end else if (addr_q == '1) begin
                                state <= S_FULL;
                                full  <= 1'b1;
                            end else begin
                                state      <= S_IDLE;
                                in_ready_q <= 1'b1;
                                addr_q     <= addr_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign state_dbg      = state;

endmodule
